// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIG_ONE = 0;
    localparam int DIG_TWO = 1;
    localparam int DIG_NEG = 2;

    function automatic int calc_iter(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/radix4_encoder.sv
// Radix-4 Booth digit decoder: {Q[1],Q[0],q_m1} -> {neg,two,one}.
module radix4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] i_triplet,
    output logic [2:0] o_digit
);

    // Triplet to signed-digit lookup; 000 and 111 both encode zero.
    always_comb begin
        o_digit = 3'b000;
        case (i_triplet)
            3'b001, 3'b010: o_digit[DIG_ONE] = 1'b1;
            3'b011:         o_digit[DIG_TWO] = 1'b1;
            3'b100: begin
                o_digit[DIG_NEG] = 1'b1;
                o_digit[DIG_TWO] = 1'b1;
            end
            3'b101, 3'b110: begin
                o_digit[DIG_NEG] = 1'b1;
                o_digit[DIG_ONE] = 1'b1;
            end
            default:        o_digit = 3'b000;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential signed radix-4 Booth multiplier with start/busy input and valid/ready output.
// Optional build macro BOOTH_ZERO_SKIP_EN: zero operands bypass RUN and go straight to DONE.
module booth_r4_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           digit_dbg
);

    localparam int ITER = calc_iter(WIDTH);
    localparam int AW   = WIDTH + 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_seq_ctrl: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_m;
    logic [AW-1:0]        r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_qm1;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;

    logic [2:0]           w_digit;
    logic [AW-1:0]        w_pp;
    logic [AW-1:0]        w_sum;
    logic                 w_zero;

`ifdef BOOTH_ZERO_SKIP_EN
    assign w_zero = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
`else
    assign w_zero = 1'b0;
`endif

    radix4_encoder u_enc (
        .i_triplet ({r_q[1], r_q[0], r_qm1}),
        .o_digit   (w_digit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE, where busy and out_valid are both low.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Partial-product select and accumulate; subtraction done as add of the ones' complement plus one.
    always_comb begin
        w_pp  = {AW{1'b0}};
        w_sum = r_acc;
        if (w_digit[DIG_ONE]) begin
            w_pp = r_m;
        end else if (w_digit[DIG_TWO]) begin
            w_pp = {r_m[AW-2:0], 1'b0};
        end else begin
            w_pp = {AW{1'b0}};
        end
        if (w_digit[DIG_NEG]) begin
            w_sum = r_acc + ~w_pp + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            w_sum = r_acc + w_pp;
        end
    end

    // Operand load in IDLE, then one accumulate plus 2-bit arithmetic shift of {A,Q,q_m1} per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= {AW{1'b0}};
            r_acc <= {AW{1'b0}};
            r_q   <= {WIDTH{1'b0}};
            r_qm1 <= 1'b0;
            r_cnt <= {CW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m   <= {{2{a[WIDTH-1]}}, a};
                        r_acc <= {AW{1'b0}};
                        r_q   <= w_zero ? {WIDTH{1'b0}} : b;
                        r_qm1 <= 1'b0;
                        r_cnt <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    r_acc <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
                    r_q   <= {w_sum[1:0], r_q[WIDTH-1:2]};
                    r_qm1 <= r_q[1];
                    r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered handshake outputs; the product is captured on the first DONE cycle and then frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= {(2*WIDTH){1'b0}};
        end else begin
            r_busy <= (w_state_nxt == RUN);
            if (r_state == DONE) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_product   <= {r_acc[WIDTH-1:0], r_q};
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign digit_dbg = (r_state == RUN) ? w_digit : 3'b000;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Self-checking bench for booth_r4_seq_ctrl (WIDTH=8) against a plain signed-multiply model.
module tb_booth_r4_seq_ctrl;

    localparam int W = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  out_ready;
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic                  busy;
    logic                  out_valid;
    logic [2*W-1:0]        product;
    logic [2:0]            digit_dbg;

    int checks = 0;
    int errors = 0;

    booth_r4_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .digit_dbg (digit_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    // Booth digit i of m: -2*m[2i+1] + m[2i] + m[2i-1], encoded {neg,two,one}
    function automatic logic [2:0] ref_digit(input logic signed [W-1:0] m, input int i);
        logic [W-1:0] u;
        int d;
        int lo;
        u = m;
        lo = 0;
        if (i > 0) lo = int'(u[2*i-1]);
        d = -2 * int'(u[2*i+1]) + int'(u[2*i]) + lo;
        case (d)
            1:       return 3'b001;
            2:       return 3'b010;
            -1:      return 3'b101;
            -2:      return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic signed [W-1:0] pick_operand();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return -8'sd128;
            1:       return 8'sd127;
            2:       return 8'sd0;
            3:       return -8'sd1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb_);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after the accepting edge; lat counts edges until out_valid is seen.
    task automatic wait_valid(output int lat, output bit saw_busy);
        lat      = 0;
        saw_busy = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, out_valid, product, digit_dbg} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b product=%h digit=%b, required all 0",
                     busy, out_valid, product, digit_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        issue(8'sd7, 8'sd3);
        for (int k = 0; k < W/2; k++) begin
            checks++;
            if (busy !== 1'b1 || digit_dbg !== ref_digit(8'sd3, k)) begin
                errors++;
                $display("FAIL basic_run[%0d]: busy=%b digit=%b, required 1 %b",
                         k, busy, digit_dbg, ref_digit(8'sd3, k));
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || digit_dbg !== 3'b000) begin
            errors++;
            $display("FAIL basic_edge4: busy=%b valid=%b digit=%b, required 0 0 000", busy, out_valid, digit_dbg);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || product !== 16'd21) begin
            errors++;
            $display("FAIL basic_edge5: valid=%b product=%h, required 1 0015", out_valid, product);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_handshake: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_corners();
        logic signed [W-1:0] ta [8] = '{-8'sd128, -8'sd128, 8'sd127, 8'sd0,  8'sd55, -8'sd1, 8'sd127, -8'sd128};
        logic signed [W-1:0] tb [8] = '{-8'sd128, 8'sd127, -8'sd128, 8'sd55, 8'sd0,  -8'sd1, 8'sd127, 8'sd0};
        int  lat;
        int  exp_lat;
        bit  saw_busy;
        bit  is_zero;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            is_zero = (ta[i] == 8'sd0) || (tb[i] == 8'sd0);
`ifdef BOOTH_ZERO_SKIP_EN
            exp_lat = is_zero ? 1 : 5;
`else
            exp_lat = 5;
`endif
            issue(ta[i], tb[i]);
            wait_valid(lat, saw_busy);
            checks++;
            if (product !== ref_mul(ta[i], tb[i]) || lat != exp_lat) begin
                errors++;
                $display("FAIL corner[%0d] %0d*%0d: product=%h lat=%0d, required %h lat=%0d",
                         i, ta[i], tb[i], product, lat, ref_mul(ta[i], tb[i]), exp_lat);
            end
            checks++;
            if (saw_busy == (exp_lat == 1)) begin
                errors++;
                $display("FAIL corner_busy[%0d]: saw_busy=%b, required %b", i, saw_busy, exp_lat != 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit saw_busy;
        logic [2*W-1:0] exp;
        exp = ref_mul(-8'sd77, 8'sd45);
        out_ready = 1'b0;
        issue(-8'sd77, 8'sd45);
        wait_valid(lat, saw_busy);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || product !== exp || busy !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b product=%h busy=%b, required 1 %h 0",
                         i, out_valid, product, busy, exp);
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b, required 0", out_valid);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_no_restart: busy=%b valid=%b, required 0 0", busy, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit saw_busy;
        out_ready = 1'b1;
        issue(8'sd5, -8'sd9);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, product, digit_dbg} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b valid=%b product=%h digit=%b, required all 0",
                     busy, out_valid, product, digit_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_aborted: valid=%b busy=%b, required 0 0", out_valid, busy);
            end
        end
        issue(8'sd5, -8'sd9);
        wait_valid(lat, saw_busy);
        checks++;
        if (product !== 16'hFFD3 || lat != 5) begin
            errors++;
            $display("FAIL reset_rerun: product=%h lat=%0d, required ffd3 lat=5", product, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        logic [2*W-1:0]      exp;
        int  lat;
        int  guard;
        bit  saw_busy;
        bit  done;
        for (int n = 0; n < 2500; n++) begin
            ra  = pick_operand();
            rb  = pick_operand();
            exp = ref_mul(ra, rb);
            out_ready = 1'($urandom_range(0, 1));
            issue(ra, rb);
            wait_valid(lat, saw_busy);
            checks++;
            if (product !== exp) begin
                errors++;
                $display("FAIL random[%0d] %0d*%0d: product=%h, required %h", n, ra, rb, product, exp);
            end
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 30) begin
                out_ready = (guard > 10) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                guard++;
                if (out_ready) begin
                    done = 1'b1;
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL random_handshake[%0d]: valid=%b, required 0", n, out_valid);
                    end
                end else if (out_valid !== 1'b1 || product !== exp) begin
                    checks++;
                    errors++;
                    $display("FAIL random_hold[%0d]: valid=%b product=%h, required 1 %h", n, out_valid, product, exp);
                end
            end
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
